// File: rtl/hex_display_ctrl_pkg.sv
// Shared definitions for the hex/decimal display controller.
//   state_e        : controller FSM states (IDLE, CONV)
//   DIGIT_OVF      : digit code shown on every digit when a decimal value
//                    does not fit on the display
//   DEF_NUM_DIGITS : default number of display digits
//   dec_max(n)     : largest decimal value representable on n digits
package hex_display_pkg;

    localparam int DEF_NUM_DIGITS = 6;

    localparam logic [7:0] DIGIT_OVF = 8'hFF;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_e;

    // 10^n - 1, evaluated at elaboration time for the range check.
    function automatic int unsigned dec_max(input int n);
        int unsigned r;
        r = 32'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 32'd10;
        end
        return r - 32'd1;
    endfunction

endpackage

// File: rtl/hex_display_ctrl_if.sv
// Host-side bundle of the display controller.
//   value/load/dec_mode/blank_lz : write strobe and its qualifiers (master drives)
//   digits/digit_oe              : per-digit code and enable toward the drivers
//   busy/overflow                : conversion in progress / last decimal too large
interface hex_display_ctrl_if
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS = DEF_NUM_DIGITS
) ();

    logic [4*NUM_DIGITS-1:0] value;
    logic                    load;
    logic                    dec_mode;
    logic                    blank_lz;
    logic [8*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   digit_oe;
    logic                    busy;
    logic                    overflow;

    modport master (
        output value, load, dec_mode, blank_lz,
        input  digits, digit_oe, busy, overflow
    );

    modport slave (
        input  value, load, dec_mode, blank_lz,
        output digits, digit_oe, busy, overflow
    );

endinterface

// File: rtl/hex_display_ctrl_bin2bcd_step.sv
// One step of the shift-and-add-3 binary-to-BCD conversion.
//   bcd_i/bin_i : current BCD accumulator and remaining binary bits
//   bcd_o/bin_o : accumulator after add-3 correction and a 1-bit left shift
//                 of the combined {bcd, bin} register
module bin2bcd_step
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int BIN_W      = 4 * NUM_DIGITS
) (
    input  logic [4*NUM_DIGITS-1:0] bcd_i,
    input  logic [BIN_W-1:0]        bin_i,
    output logic [4*NUM_DIGITS-1:0] bcd_o,
    output logic [BIN_W-1:0]        bin_o
);

    localparam int BCD_W = 4 * NUM_DIGITS;

    logic [BCD_W-1:0] adj_s;

    // Nibbles >= 5 would become >= 10 after the shift, so pre-correct by 3.
    always_comb begin
        adj_s = bcd_i;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_i[4*i +: 4] >= 4'd5) begin
                adj_s[4*i +: 4] = bcd_i[4*i +: 4] + 4'd3;
            end else begin
                adj_s[4*i +: 4] = bcd_i[4*i +: 4];
            end
        end
        bcd_o = {adj_s[BCD_W-2:0], bin_i[BIN_W-1]};
        bin_o = {bin_i[BIN_W-2:0], 1'b0};
    end

endmodule

// File: rtl/hex_display_ctrl.sv
// Display controller: captures a host value and presents it as hex or decimal
// digit codes for NUM_DIGITS 7-segment drivers, with optional leading-zero
// blanking through the per-digit enables.
//   SI_ClkIn : system clock
//   SI_Reset : asynchronous active-high reset (display dark)
//   bus      : slave side of hex_display_ctrl_if (value/load/dec_mode/blank_lz
//              in; digits/digit_oe/busy/overflow out)
module hex_display_ctrl
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int BIN_W      = 4 * NUM_DIGITS
) (
    input  logic              SI_ClkIn,
    input  logic              SI_Reset,
    hex_display_ctrl_if.slave bus
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(BIN_W);
    localparam logic [BIN_W-1:0] DEC_LIMIT = BIN_W'(dec_max(NUM_DIGITS));
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIN_W - 1);

    state_e                  state_q, state_d;
    logic [8*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   oe_q, oe_d;
    logic                    ovf_q, ovf_d;
    logic [BCD_W-1:0]        bcd_q, bcd_d;
    logic [BIN_W-1:0]        bin_q, bin_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    blank_q, blank_d;
    logic [BCD_W-1:0]        step_bcd_s;
    logic [BIN_W-1:0]        step_bin_s;
    logic                    over_s;
    logic                    last_s;
    logic                    busy_s;

    // Expand nibbles to 8-bit digit codes.
    function automatic logic [8*NUM_DIGITS-1:0] widen(input logic [BCD_W-1:0] nib);
        logic [8*NUM_DIGITS-1:0] w;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w[8*i +: 8] = {4'h0, nib[4*i +: 4]};
        end
        return w;
    endfunction

    // A digit is dark only if it and every more significant digit are zero;
    // digit 0 always stays lit.
    function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [BCD_W-1:0] nib,
                                                      input logic blank);
        logic [NUM_DIGITS-1:0] m;
        logic                  zero_above;
        m          = {NUM_DIGITS{1'b1}};
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_above = zero_above & (nib[4*i +: 4] == 4'h0);
            if (blank && zero_above) begin
                m[i] = 1'b0;
            end else begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    bin2bcd_step #(
        .NUM_DIGITS (NUM_DIGITS),
        .BIN_W      (BIN_W)
    ) u_step (
        .bcd_i (bcd_q),
        .bin_i (bin_q),
        .bcd_o (step_bcd_s),
        .bin_o (step_bin_s)
    );

    assign over_s = (bus.value > DEC_LIMIT);
    assign last_s = (cnt_q == CNT_LAST);

    // FSM state register.
    always_ff @(posedge SI_ClkIn or posedge SI_Reset) begin
        if (SI_Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: only an in-range decimal load starts a conversion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.load && bus.dec_mode && !over_s) begin
                    state_d = CONV;
                end else begin
                    state_d = IDLE;
                end
            end
            CONV: begin
                if (last_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = CONV;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy_s = 1'b0;
        case (state_q)
            IDLE:    busy_s = 1'b0;
            CONV:    busy_s = 1'b1;
            default: busy_s = 1'b0;
        endcase
    end

    // Datapath and display registers.
    always_ff @(posedge SI_ClkIn or posedge SI_Reset) begin
        if (SI_Reset) begin
            digits_q <= {(8*NUM_DIGITS){1'b0}};
            oe_q     <= {NUM_DIGITS{1'b0}};
            ovf_q    <= 1'b0;
            bcd_q    <= {BCD_W{1'b0}};
            bin_q    <= {BIN_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            blank_q  <= 1'b0;
        end else begin
            digits_q <= digits_d;
            oe_q     <= oe_d;
            ovf_q    <= ovf_d;
            bcd_q    <= bcd_d;
            bin_q    <= bin_d;
            cnt_q    <= cnt_d;
            blank_q  <= blank_d;
        end
    end

    // Datapath next state. Loads are only honoured in IDLE, so a load during
    // CONV (including its final edge) is dropped.
    always_comb begin
        digits_d = digits_q;
        oe_d     = oe_q;
        ovf_d    = ovf_q;
        bcd_d    = bcd_q;
        bin_d    = bin_q;
        cnt_d    = cnt_q;
        blank_d  = blank_q;
        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    if (!bus.dec_mode) begin
                        digits_d = widen(bus.value);
                        oe_d     = lz_mask(bus.value, bus.blank_lz);
                        ovf_d    = 1'b0;
                    end else if (over_s) begin
                        digits_d = {NUM_DIGITS{DIGIT_OVF}};
                        oe_d     = {NUM_DIGITS{1'b1}};
                        ovf_d    = 1'b1;
                    end else begin
                        bin_d    = bus.value;
                        bcd_d    = {BCD_W{1'b0}};
                        cnt_d    = {CNT_W{1'b0}};
                        blank_d  = bus.blank_lz;
                    end
                end else begin
                    digits_d = digits_q;
                end
            end
            CONV: begin
                bcd_d = step_bcd_s;
                bin_d = step_bin_s;
                cnt_d = cnt_q + CNT_W'(1);
                // Display is untouched until the final step lands.
                if (last_s) begin
                    digits_d = widen(step_bcd_s);
                    oe_d     = lz_mask(step_bcd_s, blank_q);
                    ovf_d    = 1'b0;
                    cnt_d    = {CNT_W{1'b0}};
                end else begin
                    digits_d = digits_q;
                end
            end
            default: begin
                digits_d = digits_q;
            end
        endcase
    end

    assign bus.digits   = digits_q;
    assign bus.digit_oe = oe_q;
    assign bus.overflow = ovf_q;
    assign bus.busy     = busy_s;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Self-checking bench for hex_display_ctrl (6 digits): directed vector table,
// hand-written multi-cycle sequences and randomized loads checked against an
// arithmetic reference model.
module tb_hex_display_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [47:0] cur_digits;
    logic [5:0]  cur_oe;

    hex_display_ctrl_if #(.NUM_DIGITS(6)) bus ();

    hex_display_ctrl #(.NUM_DIGITS(6)) dut (
        .SI_ClkIn (clk),
        .SI_Reset (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] v;
        logic        d;
        logic        b;
        logic [47:0] ed;
        logic [5:0]  eo;
        logic        ev;
        int          eb;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: decimal digits by division, hex digits by nibble extraction.
    function automatic void model(input logic [23:0] v, input logic d, input logic b,
                                  output logic [47:0] ed, output logic [5:0] eo,
                                  output logic ev, output int eb);
        int unsigned val, lim, p;
        int          top;
        val = v;
        lim = 1;
        for (int i = 0; i < 6; i++) lim = lim * 10;
        lim = lim - 1;
        ev  = 1'b0;
        eb  = 0;
        ed  = 48'h0;
        if (!d) begin
            for (int i = 0; i < 6; i++) ed[8*i +: 8] = 8'((val >> (4*i)) & 15);
        end else if (val > lim) begin
            ed = {6{8'hFF}};
            ev = 1'b1;
        end else begin
            eb = 24;
            p  = 1;
            for (int i = 0; i < 6; i++) begin
                ed[8*i +: 8] = 8'((val / p) % 10);
                p = p * 10;
            end
        end
        top = 0;
        for (int i = 0; i < 6; i++) if (ed[8*i +: 8] != 8'h00) top = i;
        for (int i = 0; i < 6; i++) eo[i] = ev || !b || (i <= top);
    endfunction

    // Issue one load, measure busy, confirm the display holds, then check result.
    task automatic run_load(input string name, input logic [23:0] v, input logic d,
                            input logic b, input logic [47:0] ed, input logic [5:0] eo,
                            input logic ev, input int eb);
        int   n;
        logic held;
        @(negedge clk);
        bus.value    = v;
        bus.dec_mode = d;
        bus.blank_lz = b;
        bus.load     = 1'b1;
        @(negedge clk);
        bus.load     = 1'b0;
        bus.value    = 24'($urandom);
        bus.dec_mode = 1'($urandom);
        bus.blank_lz = 1'($urandom);
        n    = 0;
        held = 1'b1;
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            if (bus.digits !== cur_digits || bus.digit_oe !== cur_oe) held = 1'b0;
            @(negedge clk);
        end
        check({name, "_busy_cycles"}, 64'(n), 64'(eb));
        check({name, "_held"}, 64'(held), 64'd1);
        check({name, "_digits"}, 64'(bus.digits), 64'(ed));
        check({name, "_oe"}, 64'(bus.digit_oe), 64'(eo));
        check({name, "_ovf"}, 64'(bus.overflow), 64'(ev));
        cur_digits = ed;
        cur_oe     = eo;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic [47:0] ed;
        logic [5:0]  eo;
        logic        ev;
        int          eb;
        logic [23:0] v;
        logic        d, b;
        int          sel;

        checks       = 0;
        failures     = 0;
        cur_digits   = 48'h0;
        cur_oe       = 6'h0;
        bus.value    = 24'h0;
        bus.load     = 1'b0;
        bus.dec_mode = 1'b0;
        bus.blank_lz = 1'b0;

        tbl[0] = '{24'h00A3F0,    1'b0, 1'b1, 48'h00_00_0A_03_0F_00, 6'b001111, 1'b0, 0};
        tbl[1] = '{24'd123456,    1'b1, 1'b0, 48'h01_02_03_04_05_06, 6'b111111, 1'b0, 24};
        tbl[2] = '{24'd999999,    1'b1, 1'b1, 48'h09_09_09_09_09_09, 6'b111111, 1'b0, 24};
        tbl[3] = '{24'd1000000,   1'b1, 1'b1, 48'hFF_FF_FF_FF_FF_FF, 6'b111111, 1'b1, 0};
        tbl[4] = '{24'h000007,    1'b0, 1'b0, 48'h00_00_00_00_00_07, 6'b111111, 1'b0, 0};
        tbl[5] = '{24'd0,         1'b1, 1'b1, 48'h00_00_00_00_00_00, 6'b000001, 1'b0, 24};
        tbl[6] = '{24'd120,       1'b1, 1'b1, 48'h00_00_00_01_02_00, 6'b000111, 1'b0, 24};
        tbl[7] = '{24'hFFFFFF,    1'b0, 1'b0, 48'h0F_0F_0F_0F_0F_0F, 6'b111111, 1'b0, 0};

        // Power-on reset.
        rst = 1'b1;
        #3;
        check("reset_digits", 64'(bus.digits), 64'h0);
        check("reset_oe", 64'(bus.digit_oe), 64'h0);
        check("reset_busy", 64'(bus.busy), 64'h0);
        check("reset_ovf", 64'(bus.overflow), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_load($sformatf("vec%0d", i), tbl[i].v, tbl[i].d, tbl[i].b,
                     tbl[i].ed, tbl[i].eo, tbl[i].ev, tbl[i].eb);
        end

        // Decimal 0 with blanking; a second load mid-conversion is ignored.
        @(negedge clk);
        bus.value = 24'd0; bus.dec_mode = 1'b1; bus.blank_lz = 1'b1; bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            if (n == 5) begin
                bus.value = 24'd42; bus.dec_mode = 1'b1; bus.blank_lz = 1'b0; bus.load = 1'b1;
            end else begin
                bus.load = 1'b0;
            end
            @(negedge clk);
        end
        bus.load = 1'b0;
        check("midload_busy_cycles", 64'(n), 64'd24);
        check("midload_digits", 64'(bus.digits), 64'h0);
        check("midload_oe", 64'(bus.digit_oe), 64'b000001);

        // Load on the final conversion edge is ignored.
        @(negedge clk);
        bus.value = 24'd55; bus.dec_mode = 1'b1; bus.blank_lz = 1'b0; bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            if (n == 24) begin
                bus.value = 24'h111111; bus.dec_mode = 1'b0; bus.load = 1'b1;
            end else begin
                bus.load = 1'b0;
            end
            @(negedge clk);
        end
        bus.load = 1'b0;
        check("endload_busy_cycles", 64'(n), 64'd24);
        check("endload_digits", 64'(bus.digits), 64'h00_00_00_00_05_05);
        @(negedge clk);
        check("endload_digits_later", 64'(bus.digits), 64'h00_00_00_00_05_05);
        check("endload_busy_later", 64'(bus.busy), 64'h0);

        // Overflow, then reset in the middle of a conversion.
        run_load("ovf_pre_rst", 24'd2000000, 1'b1, 1'b0, {6{8'hFF}}, 6'b111111, 1'b1, 0);
        @(negedge clk);
        bus.value = 24'd654321; bus.dec_mode = 1'b1; bus.blank_lz = 1'b0; bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 10) begin
            n++;
            if (n < 10) @(negedge clk);
        end
        check("rst_reached_cycle10", 64'(n), 64'd10);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_digits", 64'(bus.digits), 64'h0);
        check("midrst_oe", 64'(bus.digit_oe), 64'h0);
        check("midrst_busy", 64'(bus.busy), 64'h0);
        check("midrst_ovf", 64'(bus.overflow), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        cur_digits = 48'h0;
        cur_oe     = 6'h0;
        @(negedge clk);
        check("postrst_busy", 64'(bus.busy), 64'h0);
        run_load("postrst_hex", 24'h000007, 1'b0, 1'b0, 48'h07, 6'b111111, 1'b0, 0);

        // Randomized loads against the reference model.
        for (int k = 0; k < 40; k++) begin
            sel = $urandom_range(0, 3);
            d   = 1'($urandom_range(0, 1));
            b   = 1'($urandom_range(0, 1));
            case (sel)
                0:       v = 24'($urandom);
                3:       v = 24'($urandom_range(999990, 1000010));
                default: v = 24'($urandom_range(0, 999999));
            endcase
            model(v, d, b, ed, eo, ev, eb);
            run_load($sformatf("rnd%0d", k), v, d, b, ed, eo, ev, eb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
